// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (I) and a
//   load/store requester (D). At most one transaction is outstanding. D wins
//   by default. I wins once it has lost STARVE_LIMIT arbitrations in a row.
//   A new request may issue in the same cycle as the previous response
//   (back-to-back). A request that waits on mem_gnt_i is frozen until accepted.
//
// Ports
//   clk, resetn          : clock (rising edge), async active-low reset
//   i_req_i/i_addr_i     : fetch request and address
//   i_gnt_o              : fetch request accepted this cycle
//   i_rvalid_o/i_rdata_o : fetch response (combinational from memory)
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i : load/store request
//   d_gnt_o              : load/store request accepted this cycle
//   d_rvalid_o/d_rdata_o : load data or store ack
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o : shared port request
//   mem_gnt_i            : memory accepts the request this cycle
//   mem_rvalid_i/mem_rdata_i : response for the outstanding request
//   busy_o               : a transaction is outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_WAIT = 2'd1,
    ST_D_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  // hold_q marks a request presented but not yet accepted. hold_sel_i_q
  // remembers which requester owned it, so the selection cannot flip.
  logic       hold_q, hold_d;
  logic       hold_sel_i_q, hold_sel_i_d;

  logic       can_issue_s;
  logic       sel_i_s;
  logic       req_sel_s;

  // Arbitration: pick the requester and decide whether a request can issue
  always_comb begin
    // In a WAIT state the port frees up in the cycle the response returns.
    can_issue_s = (state_q == ST_IDLE) | mem_rvalid_i;
    if (hold_q) begin
      sel_i_s = hold_sel_i_q;
    end else if (i_req_i && (!d_req_i || (starve_q == STARVE_MAX))) begin
      sel_i_s = 1'b1;
    end else begin
      sel_i_s = 1'b0;
    end
    if (sel_i_s) begin
      req_sel_s = i_req_i;
    end else begin
      req_sel_s = d_req_i;
    end
  end

  // Shared-port request, payload mux and grant routing
  always_comb begin
    mem_req_o = resetn & can_issue_s & req_sel_s;
    if (sel_i_s) begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = i_addr_i;
      mem_wdata_o = 32'h0000_0000;
    end else begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
    i_gnt_o = mem_gnt_i & sel_i_s & mem_req_o;
    d_gnt_o = mem_gnt_i & ~sel_i_s & mem_req_o;
  end

  // Response routing to the side that owns the outstanding transaction
  always_comb begin
    i_rvalid_o = resetn & (state_q == ST_I_WAIT) & mem_rvalid_i;
    d_rvalid_o = resetn & (state_q == ST_D_WAIT) & mem_rvalid_i;
    if (state_q == ST_I_WAIT) begin
      i_rdata_o = mem_rdata_i;
    end else begin
      i_rdata_o = 32'h0000_0000;
    end
    if (state_q == ST_D_WAIT) begin
      d_rdata_o = mem_rdata_i;
    end else begin
      d_rdata_o = 32'h0000_0000;
    end
    busy_o = resetn & (state_q != ST_IDLE);
  end

  // Next-state logic for the transaction state, starvation counter and hold
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    hold_d       = mem_req_o & ~mem_gnt_i;
    hold_sel_i_d = sel_i_s;

    if (i_gnt_o) begin
      state_d = ST_I_WAIT;
    end else if (d_gnt_o) begin
      state_d = ST_D_WAIT;
    end else if ((state_q != ST_IDLE) && mem_rvalid_i) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end

    if (!i_req_i || i_gnt_o) begin
      starve_d = 4'd0;
    end else if (d_gnt_o && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers, cleared asynchronously so any outstanding transaction is dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      starve_q     <= 4'd0;
      hold_q       <= 1'b0;
      hold_sel_i_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      hold_q       <= hold_d;
      hold_sel_i_q <= hold_sel_i_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed vector table, hand-written multi-cycle sequences (starvation,
//   stall stability, reset mid-transaction), then randomized traffic compared
//   against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dwe; logic [3:0] dbe; logic [31:0] da; logic [31:0] dwd;
    logic        g;   logic rv;  logic [31:0] rd;
    logic        e_req; logic e_we; logic [3:0] e_be; logic [31:0] e_addr; logic [31:0] e_wd;
    logic        e_ig;  logic e_dg; logic e_irv; logic e_drv;
    logic [31:0] e_ird; logic [31:0] e_drd; logic e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic g, input logic rv, input logic [31:0] rd);
    i_req_i = ir; i_addr_i = ia; d_req_i = dr; d_we_i = dwe; d_be_i = dbe;
    d_addr_i = da; d_wdata_i = dwd; mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Advance to just after the next rising edge so new inputs can be applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: who owns the outstanding transaction (0 none,
  // 1 fetch, 2 data), who owns a stalled request, and the lost-arbitration run.
  int m_out, m_held, m_starve;
  int who;
  logic e_req, e_ig, e_dg, can;
  logic ig_prev, dg_prev;

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // Reset state with live requests on every input: all gated outputs low
    #2;
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 4'hF, 32'h10, 32'h1, 1'b1, 1'b1, 32'h77);
    #2;
    chk("rst mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst i_gnt", {31'h0, i_gnt_o}, 32'h0);
    chk("rst d_gnt", {31'h0, d_gnt_o}, 32'h0);
    chk("rst i_rvalid", {31'h0, i_rvalid_o}, 32'h0);
    chk("rst d_rvalid", {31'h0, d_rvalid_o}, 32'h0);
    chk("rst busy", {31'h0, busy_o}, 32'h0);
    idle_inputs();
    next_cycle();
    next_cycle();
    resetn = 1'b1;

    // ---------------- directed vector table ----------------
    //            ir   ia            dr   we   be    da          wd            g    rv   rd
    //            req  we   be    addr          wd            ig   dg   irv  drv  ird           drd           busy
    vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0013,
                1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0200, 1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_CAFE,
                1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_CAFE, 1'b1};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0055,
                1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0,
                1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1};
    vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_1234,
                1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};

    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dwe, vecs[k].dbe, vecs[k].da,
            vecs[k].dwd, vecs[k].g, vecs[k].rv, vecs[k].rd);
      #4;
      chk($sformatf("vec%0d mem_req", k), {31'h0, mem_req_o}, {31'h0, vecs[k].e_req});
      if (vecs[k].e_req) begin
        chk($sformatf("vec%0d mem_we", k), {31'h0, mem_we_o}, {31'h0, vecs[k].e_we});
        chk($sformatf("vec%0d mem_be", k), {28'h0, mem_be_o}, {28'h0, vecs[k].e_be});
        chk($sformatf("vec%0d mem_addr", k), mem_addr_o, vecs[k].e_addr);
        chk($sformatf("vec%0d mem_wdata", k), mem_wdata_o, vecs[k].e_wd);
      end
      chk($sformatf("vec%0d i_gnt", k), {31'h0, i_gnt_o}, {31'h0, vecs[k].e_ig});
      chk($sformatf("vec%0d d_gnt", k), {31'h0, d_gnt_o}, {31'h0, vecs[k].e_dg});
      chk($sformatf("vec%0d i_rvalid", k), {31'h0, i_rvalid_o}, {31'h0, vecs[k].e_irv});
      chk($sformatf("vec%0d d_rvalid", k), {31'h0, d_rvalid_o}, {31'h0, vecs[k].e_drv});
      chk($sformatf("vec%0d i_rdata", k), i_rdata_o, vecs[k].e_ird);
      chk($sformatf("vec%0d d_rdata", k), d_rdata_o, vecs[k].e_drd);
      chk($sformatf("vec%0d busy", k), {31'h0, busy_o}, {31'h0, vecs[k].e_busy});
    end

    // ---------------- starvation: D,D,D,D,I then D again ----------------
    begin
      string pat;
      logic prev_i;
      pat = "DDDDIDDDDI";
      prev_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
        next_cycle();
        drive(1'b1, 32'h0000_0400, 1'b1, 1'b0, 4'hF, 32'h0000_5000, 32'h0, 1'b1, 1'b1, 32'(c));
        #4;
        chk($sformatf("starve c%0d i_gnt", c), {31'h0, i_gnt_o}, {31'h0, (pat[c] == "I")});
        chk($sformatf("starve c%0d d_gnt", c), {31'h0, d_gnt_o}, {31'h0, (pat[c] == "D")});
        if (c > 0) begin
          chk($sformatf("starve c%0d i_rvalid", c), {31'h0, i_rvalid_o}, {31'h0, prev_i});
          chk($sformatf("starve c%0d d_rvalid", c), {31'h0, d_rvalid_o}, {31'h0, ~prev_i});
        end
        prev_i = (pat[c] == "I");
      end
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0099);
      #4;
      chk("starve drain i_rvalid", {31'h0, i_rvalid_o}, 32'h1);
      chk("starve drain i_rdata", i_rdata_o, 32'h0000_0099);
      next_cycle();
      idle_inputs();
      #4;
      chk("starve idle busy", {31'h0, busy_o}, 32'h0);
    end

    // ---------------- stability while the memory stalls ----------------
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(1'b1, 32'h0000_0300, (c > 0), 1'b1, 4'h1, 32'h0000_4000, 32'h1111_2222,
            (c == 3), 1'b0, 32'h0);
      #4;
      chk($sformatf("stall c%0d mem_req", c), {31'h0, mem_req_o}, 32'h1);
      chk($sformatf("stall c%0d mem_addr", c), mem_addr_o, 32'h0000_0300);
      chk($sformatf("stall c%0d mem_be", c), {28'h0, mem_be_o}, 32'hF);
      chk($sformatf("stall c%0d d_gnt", c), {31'h0, d_gnt_o}, 32'h0);
      chk($sformatf("stall c%0d i_gnt", c), {31'h0, i_gnt_o}, {31'h0, (c == 3)});
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h0000_4000, 32'h1111_2222, 1'b1, 1'b1, 32'h0000_0ABC);
    #4;
    chk("stall b2b i_rvalid", {31'h0, i_rvalid_o}, 32'h1);
    chk("stall b2b d_gnt", {31'h0, d_gnt_o}, 32'h1);
    chk("stall b2b mem_addr", mem_addr_o, 32'h0000_4000);
    chk("stall b2b mem_wdata", mem_wdata_o, 32'h1111_2222);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    #4;
    chk("stall store ack", {31'h0, d_rvalid_o}, 32'h1);
    next_cycle();
    idle_inputs();
    #4;
    chk("stall idle busy", {31'h0, busy_o}, 32'h0);

    // ---------------- reset in the middle of a data transaction ----------------
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_6000, 32'h0, 1'b1, 1'b0, 32'h0);
    #4;
    chk("mid d_gnt", {31'h0, d_gnt_o}, 32'h1);
    next_cycle();
    idle_inputs();
    #4;
    chk("mid busy", {31'h0, busy_o}, 32'h1);
    #1;
    resetn = 1'b0;
    drive(1'b1, 32'h1, 1'b1, 1'b0, 4'hF, 32'h2, 32'h0, 1'b1, 1'b1, 32'h0000_0BAD);
    #1;
    chk("mid rst mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("mid rst i_gnt", {31'h0, i_gnt_o}, 32'h0);
    chk("mid rst d_gnt", {31'h0, d_gnt_o}, 32'h0);
    chk("mid rst d_rvalid", {31'h0, d_rvalid_o}, 32'h0);
    chk("mid rst i_rvalid", {31'h0, i_rvalid_o}, 32'h0);
    chk("mid rst busy", {31'h0, busy_o}, 32'h0);
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0BAD);
    #4;
    chk("post rst stray d_rvalid", {31'h0, d_rvalid_o}, 32'h0);
    chk("post rst stray i_rvalid", {31'h0, i_rvalid_o}, 32'h0);
    chk("post rst stray d_rdata", d_rdata_o, 32'h0);
    chk("post rst busy", {31'h0, busy_o}, 32'h0);
    next_cycle();
    idle_inputs();
    #4;
    chk("post rst idle busy", {31'h0, busy_o}, 32'h0);

    // ---------------- randomized traffic against the reference model ----------------
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    m_out = 0; m_held = 0; m_starve = 0;
    ig_prev = 1'b0; dg_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      // Requesters keep request and payload until granted, occasionally giving up.
      if (!i_req_i || ig_prev) begin
        i_req_i  = ($urandom_range(0, 9) < 6);
        i_addr_i = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        i_req_i = 1'b0;
      end
      if (!d_req_i || dg_prev) begin
        d_req_i   = ($urandom_range(0, 9) < 6);
        d_we_i    = 1'($urandom_range(0, 1));
        d_be_i    = 4'($urandom_range(0, 15));
        d_addr_i  = $urandom;
        d_wdata_i = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        d_req_i = 1'b0;
      end
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = (m_out != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      mem_rdata_i  = $urandom;
      #4;

      can = (m_out == 0) || mem_rvalid_i;
      if (m_held != 0) who = m_held;
      else if (i_req_i && (!d_req_i || (m_starve == STARVE_LIMIT))) who = 1;
      else who = 2;
      e_req = can && ((who == 1) ? i_req_i : d_req_i);
      e_ig  = e_req && mem_gnt_i && (who == 1);
      e_dg  = e_req && mem_gnt_i && (who == 2);

      chk("rnd mem_req", {31'h0, mem_req_o}, {31'h0, e_req});
      if (e_req) begin
        chk("rnd mem_addr", mem_addr_o, (who == 1) ? i_addr_i : d_addr_i);
        chk("rnd mem_we", {31'h0, mem_we_o}, (who == 1) ? 32'h0 : {31'h0, d_we_i});
        chk("rnd mem_be", {28'h0, mem_be_o}, (who == 1) ? 32'hF : {28'h0, d_be_i});
        chk("rnd mem_wdata", mem_wdata_o, (who == 1) ? 32'h0 : d_wdata_i);
      end
      chk("rnd i_gnt", {31'h0, i_gnt_o}, {31'h0, e_ig});
      chk("rnd d_gnt", {31'h0, d_gnt_o}, {31'h0, e_dg});
      chk("rnd i_rvalid", {31'h0, i_rvalid_o}, {31'h0, (m_out == 1) && mem_rvalid_i});
      chk("rnd d_rvalid", {31'h0, d_rvalid_o}, {31'h0, (m_out == 2) && mem_rvalid_i});
      chk("rnd i_rdata", i_rdata_o, (m_out == 1) ? mem_rdata_i : 32'h0);
      chk("rnd d_rdata", d_rdata_o, (m_out == 2) ? mem_rdata_i : 32'h0);
      chk("rnd busy", {31'h0, busy_o}, {31'h0, (m_out != 0)});

      // Advance the model across the coming clock edge.
      m_held = (e_req && !mem_gnt_i) ? who : 0;
      if (!i_req_i || e_ig) m_starve = 0;
      else if (e_dg && (m_starve < STARVE_LIMIT)) m_starve = m_starve + 1;
      if (e_ig) m_out = 1;
      else if (e_dg) m_out = 2;
      else if (mem_rvalid_i) m_out = 0;
      ig_prev = e_ig;
      dg_prev = e_dg;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch gets priority (1..15).
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  sole clock, rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- i_req_i  input  1  fetch request.
- i_addr_i  input  32  fetch address.
- i_gnt_o  output  1  fetch request accepted this cycle.
- i_rvalid_o  output  1  fetch data valid.
- i_rdata_o  output  32  fetch data.
- d_req_i  input  1  load/store request.
- d_we_i  input  1  1 = store.
- d_be_i  input  4  store byte enables.
- d_addr_i  input  32  data address.
- d_wdata_i  input  32  store data.
- d_gnt_o  output  1  data request accepted this cycle.
- d_rvalid_o  output  1  data response, load data or store ack.
- d_rdata_o  output  32  load data.
- mem_req_o  output  1  shared-port request.
- mem_we_o  output  1  shared-port write.
- mem_be_o  output  4  shared-port byte enables (4'hF for fetch).
- mem_addr_o  output  32  shared-port address.
- mem_wdata_o  output  32  shared-port write data.
- mem_gnt_i  input  1  memory accepts request this cycle.
- mem_rvalid_i  input  1  response for the single outstanding request.
- mem_rdata_i  input  32  response data.
- busy_o  output  1  a transaction is outstanding.

Function
REQ-003 SHALL share one memory port between fetch (I) and load/store (D), with at most one outstanding transaction.
REQ-004 SHALL implement states IDLE, I_WAIT, D_WAIT; accept of an I request -> I_WAIT, accept of a D request -> D_WAIT, mem_rvalid_i in a WAIT state -> IDLE unless a new request is accepted in the same cycle.
REQ-005 SHALL issue a new request when state is IDLE, or in a WAIT state in the cycle mem_rvalid_i is high (back-to-back, zero bubble).
REQ-006 SHALL select D over I by default; SHALL select I when the starvation counter equals STARVE_LIMIT.
REQ-007 SHALL drive mem_* combinationally from the selected requester; mem_be_o = 4'hF and mem_we_o = 0 and mem_wdata_o = 0 for I.
REQ-008 SHALL route mem_gnt_i combinationally: i_gnt_o = mem_gnt_i & sel_I & mem_req_o; d_gnt_o likewise for D; never both high.
REQ-009 SHALL hold the selection and all mem_* outputs stable while mem_req_o=1 and mem_gnt_i=0, even if the other requester arrives or the starvation counter saturates.
REQ-010 SHALL route mem_rvalid_i/mem_rdata_i to i_* in I_WAIT and to d_* in D_WAIT, same cycle, no registering; rdata of the other side SHALL be 0.
REQ-011 SHALL count, saturating at STARVE_LIMIT, each cycle i_req_i=1 and D is granted; SHALL clear the counter on I grant or when i_req_i=0.
REQ-012 SHALL ignore mem_rvalid_i in IDLE (no rvalid forwarded, no state change).
REQ-013 SHALL assert busy_o iff state is I_WAIT or D_WAIT.
REQ-014 SHALL treat requesters as holding req and payload until their gnt; a request dropped before gnt SHALL simply not be issued once the hold (REQ-009) no longer applies.

Reset
REQ-015 SHALL, on resetn low, asynchronously set state IDLE, starvation counter 0 and selection hold cleared.
REQ-016 SHALL force mem_req_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o and busy_o to 0 while resetn is low, i.e. gate the combinational paths with resetn.
REQ-017 SHALL discard an outstanding transaction on reset; a mem_rvalid_i arriving after reset release SHALL be ignored per REQ-012.

Verification
REQ-018 SHALL verify fetch-only traffic: i_req_i=1 at 0x80000000, mem_gnt_i=1, mem_rvalid_i 1 cycle later with 0x00000013 -> i_gnt_o pulse, then i_rvalid_o=1 with i_rdata_o=0x00000013, state I_WAIT->IDLE.
REQ-019 SHALL verify a collision: i_req_i and d_req_i (load at 0x1000) both rise in IDLE -> D granted first; I granted in the cycle D's rvalid returns (back-to-back).
REQ-020 SHALL verify starvation: STARVE_LIMIT=4, I and D requesting continuously with immediate gnt/rvalid -> D wins 4 arbitrations, I wins the 5th, then the counter reads 0.
REQ-021 SHALL verify stability: I selected, mem_gnt_i=0 for 3 cycles while d_req_i rises -> mem_addr_o stays the I address, d_gnt_o=0, and I is accepted on cycle 4.
REQ-022 SHALL verify store ack: d_we_i=1, d_be_i=4'b0011, d_wdata_i=0xDEADBEEF -> mem_we_o=1 and mem_be_o=0011, and d_rvalid_o pulses on mem_rvalid_i.
REQ-023 SHALL verify reset mid-operation: resetn low while in D_WAIT, then a stray mem_rvalid_i after release -> all outputs 0, d_rvalid_o stays 0, state IDLE.
